imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 167 ++++++++++++++++
 tb/tb_imem_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder -- instruction memory responder for an RV32 fetch port.
//
// Models an OBI-style instruction memory. A request is granted after an
// optional number of wait cycles. The addressed word is then returned a fixed
// number of cycles after the grant, through a shift pipeline with no
// back-pressure. A separate preload port writes the memory; a preload
// always wins over a fetch in the same cycle.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          synchronous active-low reset
//   instr_req_i     fetch request
//   instr_addr_i    fetch byte address
//   instr_gnt_o     request accepted this cycle (combinational)
//   instr_rvalid_o  response valid
//   instr_rdata_o   response word (0 when no response)
//   instr_err_o     response is an error (misaligned / out of range)
//   load_we_i       preload write strobe
//   load_addr_i     preload byte address
//   load_wdata_i    preload data
//   busy_o          FSM not idle, or a response is in flight

package rv32_pkg;
  localparam logic [31:0] RESET_ADDR = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
endpackage

module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = rv32_pkg::RESET_ADDR,
  parameter int unsigned GNT_WAIT    = 0,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic        busy_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GRANT
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Address decode. The subtraction may wrap, so the below-base case is
  // caught by a direct compare rather than by inspecting the offset.
  logic [31:0] rd_off, ld_off;
  logic [AW-1:0] rd_idx, ld_idx;
  logic        rd_bad, ld_bad;

  assign rd_off = instr_addr_i - BASE_ADDR;
  assign ld_off = load_addr_i - BASE_ADDR;
  assign rd_idx = rd_off[AW+1:2];
  assign ld_idx = ld_off[AW+1:2];
  assign rd_bad = (instr_addr_i[1:0] != 2'b00) || (instr_addr_i < BASE_ADDR) ||
                  ((rd_off >> 2) >= DEPTH_WORDS);
  assign ld_bad = (load_addr_i[1:0] != 2'b00) || (load_addr_i < BASE_ADDR) ||
                  ((ld_off >> 2) >= DEPTH_WORDS);

  // With GNT_WAIT=0 the idle state grants directly, which lets a held
  // request be granted every cycle (IDLE and GRANT alternate).
  assign instr_gnt_o = ((state_q == S_GRANT) || ((state_q == S_IDLE) && (GNT_WAIT == 0))) &&
                       instr_req_i && !load_we_i;

  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // A preload freezes the FSM and the wait counter.
    if (!load_we_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (instr_req_i) begin
            if (GNT_WAIT == 0) begin
              state_d = S_GRANT;
            end else begin
              state_d = S_WAIT;
              cnt_d   = 3'(GNT_WAIT - 1);
            end
          end
        end
        S_WAIT: begin
          if (!instr_req_i) begin
            // Abandoned request: no grant is ever issued for it.
            state_d = S_IDLE;
            cnt_d   = 3'd0;
          end else if (cnt_q <= 3'd1) begin
            state_d = S_GRANT;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        S_GRANT: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the memory has no reset; preloaded code must survive a reset.
  always_ff @(posedge clk_i) begin
    if (load_we_i && !ld_bad) begin
      mem[ld_idx] <= load_wdata_i;
    end
  end

  // Response pipeline: stage 0 captures the granted read, the last stage
  // drives the outputs. Only the valid bits are reset; payload is qualified.
  logic [LATENCY-1:0] pipe_valid;
  logic [31:0]        pipe_data [LATENCY];
  logic               pipe_err  [LATENCY];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= instr_gnt_o;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_data[0] <= rd_bad ? rv32_pkg::NOP_INSTR : mem[rd_idx];
    pipe_err[0]  <= rd_bad;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_err[i]  <= pipe_err[i-1];
    end
  end

  assign instr_rvalid_o = pipe_valid[LATENCY-1];
  assign instr_rdata_o  = instr_rvalid_o ? pipe_data[LATENCY-1] : 32'h0;
  assign instr_err_o    = instr_rvalid_o && pipe_err[LATENCY-1];
  assign busy_o         = (state_q != S_IDLE) || (|pipe_valid);

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder -- directed bench for imem_responder.
//
// Three instances share clock and reset:
//   dut0: GNT_WAIT=0, LATENCY=1  (back-to-back, errors, load priority)
//   dut1: GNT_WAIT=2, LATENCY=2  (wait states, abandoned request)
//   dut2: GNT_WAIT=0, LATENCY=3  (reset flush of in-flight responses)
// Inputs change just after the falling edge; outputs are sampled 1 ns later.

module tb_imem_responder;

  localparam logic [31:0] BASE = rv32_pkg::RESET_ADDR;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        req    [3];
  logic [31:0] addr   [3];
  logic        we     [3];
  logic [31:0] laddr  [3];
  logic [31:0] ldata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];
  logic        busy   [3];

  int passed = 0;
  int total  = 0;

  imem_responder #(.DEPTH_WORDS(1024), .GNT_WAIT(0), .LATENCY(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(req[0]), .instr_addr_i(addr[0]), .instr_gnt_o(gnt[0]),
    .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
    .load_we_i(we[0]), .load_addr_i(laddr[0]), .load_wdata_i(ldata[0]),
    .busy_o(busy[0])
  );

  imem_responder #(.DEPTH_WORDS(1024), .GNT_WAIT(2), .LATENCY(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(req[1]), .instr_addr_i(addr[1]), .instr_gnt_o(gnt[1]),
    .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
    .load_we_i(we[1]), .load_addr_i(laddr[1]), .load_wdata_i(ldata[1]),
    .busy_o(busy[1])
  );

  imem_responder #(.DEPTH_WORDS(1024), .GNT_WAIT(0), .LATENCY(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(req[2]), .instr_addr_i(addr[2]), .instr_gnt_o(gnt[2]),
    .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]), .instr_err_o(err[2]),
    .load_we_i(we[2]), .load_addr_i(laddr[2]), .load_wdata_i(ldata[2]),
    .busy_o(busy[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic drive(input int i, input logic r, input logic [31:0] a,
                       input logic w, input logic [31:0] la, input logic [31:0] ld);
    req[i]   = r;
    addr[i]  = a;
    we[i]    = w;
    laddr[i] = la;
    ldata[i] = ld;
  endtask

  task automatic preload(input int i, input logic [31:0] la, input logic [31:0] ld);
    @(negedge clk);
    drive(i, 1'b0, 32'h0, 1'b1, la, ld);
    @(negedge clk);
    drive(i, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({rvalid[i], err[i], rdata[i], busy[i]} !== 35'h0)
        $display("FAIL reset_outputs dut%0d: rvalid=%b err=%b rdata=%h busy=%b, want all 0",
                 i, rvalid[i], err[i], rdata[i], busy[i]);
      else passed++;
    end
    // Grant stays combinational during reset.
    drive(0, 1'b1, BASE, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, BASE, 1'b0, 32'h0, 32'h0);
    #1;
    total++;
    if (gnt[0] !== 1'b1) $display("FAIL reset_gnt_nowait: got %b want 1", gnt[0]);
    else passed++;
    total++;
    if (gnt[1] !== 1'b0) $display("FAIL reset_gnt_wait2: got %b want 0", gnt[1]);
    else passed++;
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    #1;
    total++;
    if ({rvalid[0], busy[0], rvalid[1], busy[1]} !== 4'b0)
      $display("FAIL reset_held_req: rvalid0=%b busy0=%b rvalid1=%b busy1=%b, want 0",
               rvalid[0], busy[0], rvalid[1], busy[1]);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    preload(0, BASE,      32'h0050_0093);
    preload(0, BASE + 4,  32'h1111_1111);
    preload(0, BASE + 8,  32'h2222_2222);
    @(negedge clk); drive(0, 1'b1, BASE, 1'b0, 32'h0, 32'h0); #1;
    total++;
    if ({gnt[0], rvalid[0]} !== 2'b10)
      $display("FAIL b2b_c1: gnt=%b rvalid=%b, want gnt=1 rvalid=0", gnt[0], rvalid[0]);
    else passed++;
    @(negedge clk); drive(0, 1'b1, BASE + 4, 1'b0, 32'h0, 32'h0); #1;
    total++;
    if ({gnt[0], rvalid[0], err[0], rdata[0]} !== {3'b110, 32'h0050_0093})
      $display("FAIL b2b_c2: gnt=%b rvalid=%b err=%b rdata=%h, want 1 1 0 00500093",
               gnt[0], rvalid[0], err[0], rdata[0]);
    else passed++;
    @(negedge clk); drive(0, 1'b1, BASE + 8, 1'b0, 32'h0, 32'h0); #1;
    total++;
    if ({gnt[0], rvalid[0], err[0], rdata[0]} !== {3'b110, 32'h1111_1111})
      $display("FAIL b2b_c3: gnt=%b rvalid=%b err=%b rdata=%h, want 1 1 0 11111111",
               gnt[0], rvalid[0], err[0], rdata[0]);
    else passed++;
    @(negedge clk); drive(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0); #1;
    total++;
    if ({gnt[0], rvalid[0], err[0], rdata[0]} !== {3'b010, 32'h2222_2222})
      $display("FAIL b2b_c4: gnt=%b rvalid=%b err=%b rdata=%h, want 0 1 0 22222222",
               gnt[0], rvalid[0], err[0], rdata[0]);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({gnt[0], rvalid[0], err[0], rdata[0], busy[0]} !== 36'h0)
      $display("FAIL b2b_drain: gnt=%b rvalid=%b err=%b rdata=%h busy=%b, want all 0",
               gnt[0], rvalid[0], err[0], rdata[0], busy[0]);
    else passed++;
  endtask

  task automatic test_wait_states();
    preload(1, BASE + 12, 32'hCAFE_0003);
    @(negedge clk); drive(1, 1'b1, BASE + 12, 1'b0, 32'h0, 32'h0); #1;
    total++;
    if ({gnt[1], busy[1]} !== 2'b00)
      $display("FAIL wait_c1: gnt=%b busy=%b, want 0 0", gnt[1], busy[1]);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({gnt[1], busy[1]} !== 2'b01)
      $display("FAIL wait_c2: gnt=%b busy=%b, want 0 1", gnt[1], busy[1]);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({gnt[1], busy[1]} !== 2'b11)
      $display("FAIL wait_c3_grant: gnt=%b busy=%b, want 1 1", gnt[1], busy[1]);
    else passed++;
    @(negedge clk); drive(1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0); #1;
    total++;
    if ({gnt[1], rvalid[1]} !== 2'b00)
      $display("FAIL wait_c4: gnt=%b rvalid=%b, want 0 0", gnt[1], rvalid[1]);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({rvalid[1], err[1], rdata[1]} !== {2'b10, 32'hCAFE_0003})
      $display("FAIL wait_resp: rvalid=%b err=%b rdata=%h, want 1 0 cafe0003",
               rvalid[1], err[1], rdata[1]);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({rvalid[1], busy[1]} !== 2'b00)
      $display("FAIL wait_drain: rvalid=%b busy=%b, want 0 0", rvalid[1], busy[1]);
    else passed++;
    // Abandoned request: one cycle of req, then dropped while waiting.
    @(negedge clk); drive(1, 1'b1, BASE + 12, 1'b0, 32'h0, 32'h0); #1;
    @(negedge clk); drive(1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0); #1;
    total++;
    if ({gnt[1], busy[1]} !== 2'b01)
      $display("FAIL abandon_in_wait: gnt=%b busy=%b, want 0 1", gnt[1], busy[1]);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      total++;
      if ({gnt[1], rvalid[1], busy[1]} !== 3'b000)
        $display("FAIL abandon_after%0d: gnt=%b rvalid=%b busy=%b, want 0 0 0",
                 k, gnt[1], rvalid[1], busy[1]);
      else passed++;
    end
  endtask

  task automatic test_errors();
    logic [31:0] ea [6];
    logic        ee [6];
    logic [31:0] ed [6];
    ea = '{BASE + 2, BASE - 4, BASE + 4096, 32'h0, BASE + 4092, BASE + 4};
    ee = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ed = '{NOP, NOP, NOP, NOP, 32'hDEAD_BEEF, 32'h1111_1111};
    preload(0, BASE + 4092, 32'hDEAD_BEEF);
    // Misaligned preload must not touch word 1.
    preload(0, BASE + 6, 32'h0BAD_0BAD);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) drive(0, 1'b1, ea[k], 1'b0, 32'h0, 32'h0);
      else       drive(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      #1;
      if (k < 6) begin
        total++;
        if (gnt[0] !== 1'b1) $display("FAIL err_gnt%0d: got %b want 1", k, gnt[0]);
        else passed++;
      end
      if (k > 0) begin
        total++;
        if ({rvalid[0], err[0], rdata[0]} !== {1'b1, ee[k-1], ed[k-1]})
          $display("FAIL err_resp%0d addr=%h: rvalid=%b err=%b rdata=%h, want 1 %b %h",
                   k - 1, ea[k-1], rvalid[0], err[0], rdata[0], ee[k-1], ed[k-1]);
        else passed++;
      end
    end
  endtask

  task automatic test_load_priority();
    @(negedge clk); drive(0, 1'b1, BASE + 20, 1'b1, BASE + 20, 32'h0A0B_0C0D); #1;
    total++;
    if (gnt[0] !== 1'b0) $display("FAIL load_blocks_gnt: got %b want 0", gnt[0]);
    else passed++;
    @(negedge clk); drive(0, 1'b1, BASE + 20, 1'b0, 32'h0, 32'h0); #1;
    total++;
    if (gnt[0] !== 1'b1) $display("FAIL load_then_gnt: got %b want 1", gnt[0]);
    else passed++;
    @(negedge clk); drive(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0); #1;
    total++;
    if ({rvalid[0], err[0], rdata[0]} !== {2'b10, 32'h0A0B_0C0D})
      $display("FAIL load_readback: rvalid=%b err=%b rdata=%h, want 1 0 0a0b0c0d",
               rvalid[0], err[0], rdata[0]);
    else passed++;
  endtask

  task automatic test_reset_flush();
    preload(2, BASE,     32'hA000_0000);
    preload(2, BASE + 4, 32'hA111_1111);
    preload(2, BASE + 8, 32'hA222_2222);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(2, 1'b1, BASE + 32'(4 * k), 1'b0, 32'h0, 32'h0); #1;
      total++;
      if (gnt[2] !== 1'b1) $display("FAIL flush_gnt%0d: got %b want 1", k, gnt[2]);
      else passed++;
    end
    @(negedge clk); drive(2, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0); rst_n = 1'b0; #1;
    total++;
    if ({rvalid[2], rdata[2]} !== {1'b1, 32'hA000_0000})
      $display("FAIL flush_first_resp: rvalid=%b rdata=%h, want 1 a0000000", rvalid[2], rdata[2]);
    else passed++;
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if ({rvalid[2], err[2], rdata[2], busy[2]} !== 35'h0)
      $display("FAIL flush_after_reset: rvalid=%b err=%b rdata=%h busy=%b, want all 0",
               rvalid[2], err[2], rdata[2], busy[2]);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      total++;
      if ({rvalid[2], busy[2]} !== 2'b00)
        $display("FAIL flush_dropped%0d: rvalid=%b busy=%b, want 0 0", k, rvalid[2], busy[2]);
      else passed++;
    end
    // Memory contents survive reset.
    @(negedge clk); drive(2, 1'b1, BASE + 4, 1'b0, 32'h0, 32'h0); #1;
    @(negedge clk); drive(2, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    total++;
    if (rvalid[2] !== 1'b0) $display("FAIL flush_early_rvalid: got %b want 0", rvalid[2]);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({rvalid[2], err[2], rdata[2]} !== {2'b10, 32'hA111_1111})
      $display("FAIL flush_mem_kept: rvalid=%b err=%b rdata=%h, want 1 0 a1111111",
               rvalid[2], err[2], rdata[2]);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_load_priority();
    test_reset_flush();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
